// File: rtl/serial_cla_addsub_pkg.sv
// Shared constants and FSM encoding for the nibble-serial add/subtract unit.
package serial_cla_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_cla_addsub_if.sv
// Operand/result handshake bundle: valid/ready in, valid/ready out.
interface serial_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The arithmetic unit itself
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_cla_addsub_cla_nibble.sv
// 4-bit carry propagate/generate slice and the lookahead resolver built on it.
module carry_prop_block
    import serial_cla_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    output logic [NIBBLE_W-1:0] o_p,
    output logic [NIBBLE_W-1:0] o_g
);
    assign o_p = i_a ^ i_b;
    assign o_g = i_a & i_b;
endmodule

module cla_nibble
    import serial_cla_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_s,
    output logic                o_c3,
    output logic                o_c4
);
    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_g;
    logic                w_c1;
    logic                w_c2;
    logic                w_c3;
    logic                w_c4;

    carry_prop_block u_pg (
        .i_a (i_a),
        .i_b (i_b),
        .o_p (w_p),
        .o_g (w_g)
    );

    // Flattened lookahead: every carry is a two-level function of P, G and cin
    assign w_c1 = w_g[0] | (w_p[0] & i_cin);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s  = w_p ^ {w_c3, w_c2, w_c1, i_cin};
    assign o_c3 = w_c3;
    assign o_c4 = w_c4;
endmodule

// File: rtl/serial_cla_addsub.sv
// Nibble-serial WIDTH-bit add/subtract: one 4-bit lookahead step per cycle,
// ripple carry held in a register between nibbles.
module serial_cla_addsub
    import serial_cla_addsub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    serial_cla_addsub_if.slave   bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t                           r_state;
    logic [NIB-1:0][NIBBLE_W-1:0]     r_a;
    logic [NIB-1:0][NIBBLE_W-1:0]     r_b;
    logic [NIB-1:0][NIBBLE_W-1:0]     r_sum;
    logic                             r_carry;
    logic [CNT_W-1:0]                 r_cnt;
    logic                             r_cout;
    logic                             r_ovf;
    logic                             r_out_valid;

    logic [NIBBLE_W-1:0]              w_s;
    logic                             w_c3;
    logic                             w_c4;
    logic                             w_last;

    // Single shared lookahead slice, fed by the nibble selected by the counter
    cla_nibble u_cla (
        .i_a   (r_a[r_cnt]),
        .i_b   (r_b[r_cnt]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_c3  (w_c3),
        .o_c4  (w_c4)
    );

    assign w_last = (r_cnt == CNT_W'(NIB - 1));

    // Control FSM with operand capture, per-nibble accumulation and result hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is A + ~B + 1: invert B once here, carry-in 1
                        r_a     <= bus.a;
                        r_b     <= bus.b ^ {WIDTH{bus.sub}};
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[r_cnt] <= w_s;
                    r_carry      <= w_c4;
                    if (w_last) begin
                        // Carry into vs out of the MSB gives signed overflow
                        r_cout      <= w_c4;
                        r_ovf       <= w_c3 ^ w_c4;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_cla_addsub.sv
// Directed + randomized check of the nibble-serial add/subtract unit.
module tb_serial_cla_addsub;
    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    serial_cla_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_cla_addsub #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check latency and result, then hand it off
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] e_sum,
                         input logic e_cout, input logic e_ovf);
        int edges;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        tick();
        edges        = 1;
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.sub      = ~sub;
        chk({tag, "_busy"}, bus.in_ready, 0);
        while (!bus.out_valid && edges < 40) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, edges, NIB + 1);
        chk({tag, "_sum"}, bus.sum, e_sum);
        chk({tag, "_cout"}, bus.cout, e_cout);
        chk({tag, "_ovf"}, bus.ovf, e_ovf);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, bus.out_valid, 0);
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bb;
        logic [32:0] r;
        logic        v;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
        v  = (a[31] == bb[31]) && (r[31] != a[31]);
        return {v, r};
    endfunction

    initial begin
        logic [33:0] m;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          edges;
        n_chk         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst = 1'b0;
        tick();

        do_op("add_5_3",   32'h5,        32'h3,        1'b0, 32'h8,        1'b0, 1'b0);
        do_op("add_ff_1",  32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1'b1, 1'b0);
        do_op("add_7f_1",  32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 1'b0, 1'b1);
        do_op("sub_80_1",  32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        do_op("sub_5_7",   32'h5,        32'h7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sub_7_7",   32'h7,        32'h7,        1'b1, 32'h0,        1'b1, 1'b0);
        do_op("add_80_80", 32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1, 1'b1);
        do_op("add_mix",   32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 1'b0, 1'b0);

        // Backpressure: result held, new operands ignored until handoff
        bus.a = 32'h10; bus.b = 32'h20; bus.sub = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.a = 32'h1; bus.b = 32'h1;
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            tick();
            edges++;
        end
        chk("bp_arrive", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_sum", bus.sum, 32'h30);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_handoff_valid", bus.out_valid, 0);
        chk("bp_handoff_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_next_accept", bus.in_ready, 0);
        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            tick();
            edges++;
        end
        chk("bp_next_sum", bus.sum, 32'h2);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset mid-RUN at cnt=3 aborts the op
        bus.a = 32'h12345678; bus.b = 32'h1; bus.sub = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_sum", bus.sum, 0);
        do_op("add_2_2", 32'h2, 32'h2, 1'b0, 32'h4, 1'b0, 1'b0);

        // Random back-to-back ops against the behavioural model
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            m  = model(ra, rb, rs);
            do_op("rand", ra, rb, rs, m[31:0], m[32], m[33]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
